// File: rtl/seq_divider_const.sv
// Sequential restoring divider with constant, data-independent latency.
// One quotient bit per ITER_SHIFT/ITER_SUB pair; results publish in DONE.
module seq_divider_const #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER_SHIFT,
        ITER_SUB,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [WIDTH:0]  prem;
    logic [WIDTH-1:0] dreg;
    logic [WIDTH-1:0] dsor;
    logic            dbz_r;
    logic [WIDTH:0]  diff;
    logic [WIDTH:0]  prem_nx;
    logic            ge;
    logic            last;

    assign ge      = prem >= {1'b0, dsor};
    assign diff    = prem - {1'b0, dsor};
    assign prem_nx = ge ? diff : prem;
    assign last    = cnt == CW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = LOAD;
            end
            LOAD:       state_nx = ITER_SHIFT;
            ITER_SHIFT: state_nx = ITER_SUB;
            ITER_SUB:   state_nx = last ? DONE : ITER_SHIFT;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs load on the final ITER_SUB edge so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            prem        <= '0;
            dreg        <= '0;
            dsor        <= '0;
            dbz_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dreg  <= dividend;
                        dsor  <= divisor;
                        dbz_r <= divisor == '0;
                    end
                end
                LOAD: begin
                    prem <= '0;
                    cnt  <= CW'(WIDTH);
                end
                ITER_SHIFT: begin
                    {prem, dreg} <= {prem, dreg} << 1;
                end
                ITER_SUB: begin
                    prem    <= prem_nx;
                    dreg[0] <= ge;
                    cnt     <= cnt - CW'(1);
                    if (last) begin
                        quotient    <= {dreg[WIDTH-1:1], ge};
                        remainder   <= prem_nx[WIDTH-1:0];
                        div_by_zero <= dbz_r;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
